// File: rtl/aes_inv_sbox_stream.sv
// Streaming AES InvSubBytes engine, NUM_LANES bytes/beat, 2-stage pipe.
// Optional forward S-box mode selected per beat when AES_FWD_SBOX_EN is defined.
module aes_inv_sbox_stream #(
  parameter int NUM_LANES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [8*NUM_LANES-1:0] in_data,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [8*NUM_LANES-1:0] out_data,
  output logic                   out_last,
  output logic                   err_frame,
  input  logic                   clr_err
`ifdef AES_FWD_SBOX_EN
  ,
  input  logic                   mode_fwd
`endif
);

  localparam int WPB = 16 / NUM_LANES;
  localparam int CW  = (WPB > 1) ? $clog2(WPB) : 1;
  localparam int DW  = 8 * NUM_LANES;
  localparam logic [CW-1:0] CNT_MAX = CW'(WPB - 1);

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  // a^254 == a^-1 in GF(2^8); maps 0 to 0 naturally
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = a;
    for (int i = 0; i < 7; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] inv_aff(input logic [7:0] x);
    logic [7:0] y;
    logic [7:0] c;
    c = 8'h05;
    y = 8'h00;
    for (int i = 0; i < 8; i++) begin
      y[i] = x[(i + 2) % 8] ^ x[(i + 5) % 8]
           ^ x[(i + 7) % 8] ^ c[i];
    end
    return y;
  endfunction

`ifdef AES_FWD_SBOX_EN
  function automatic logic [7:0] fwd_aff(input logic [7:0] x);
    logic [7:0] y;
    logic [7:0] c;
    c = 8'h63;
    y = 8'h00;
    for (int i = 0; i < 8; i++) begin
      y[i] = x[i] ^ x[(i + 4) % 8] ^ x[(i + 5) % 8]
           ^ x[(i + 6) % 8] ^ x[(i + 7) % 8] ^ c[i];
    end
    return y;
  endfunction
`endif

  logic          adv;
  logic          accept;
  logic [CW-1:0] cnt;
  logic          cnt_end;
  logic          beat_last;
  logic          frame_bad;
  logic          s1_valid;
  logic          s1_last;
  logic [DW-1:0] s1_data;
  logic [DW-1:0] s1_nxt;
  logic [DW-1:0] s2_nxt;
`ifdef AES_FWD_SBOX_EN
  logic          s1_fwd;
`endif

  assign adv       = !out_valid || out_ready;
  assign in_ready  = rst_n && adv;
  assign accept    = in_valid && in_ready;
  assign cnt_end   = (cnt == CNT_MAX);
  assign beat_last = cnt_end || in_last;
  assign frame_bad = in_last ^ cnt_end;

  always_comb begin
    s1_nxt = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
`ifdef AES_FWD_SBOX_EN
      s1_nxt[8*k +: 8] = mode_fwd ? gf_inv(in_data[8*k +: 8])
                                  : inv_aff(in_data[8*k +: 8]);
`else
      s1_nxt[8*k +: 8] = inv_aff(in_data[8*k +: 8]);
`endif
    end
  end

  always_comb begin
    s2_nxt = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
`ifdef AES_FWD_SBOX_EN
      s2_nxt[8*k +: 8] = s1_fwd ? fwd_aff(s1_data[8*k +: 8])
                                : gf_inv(s1_data[8*k +: 8]);
`else
      s2_nxt[8*k +: 8] = gf_inv(s1_data[8*k +: 8]);
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      err_frame <= 1'b0;
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      s1_data   <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
`ifdef AES_FWD_SBOX_EN
      s1_fwd    <= 1'b0;
`endif
    end else begin
      // a premature in_last resyncs the counter to the sender
      if (accept) begin
        cnt <= beat_last ? '0 : cnt + 1'b1;
      end
      if (accept && frame_bad) begin
        err_frame <= 1'b1;
      end else if (clr_err) begin
        err_frame <= 1'b0;
      end
      if (adv) begin
        s1_valid  <= accept;
        out_valid <= s1_valid;
        if (accept) begin
          s1_data <= s1_nxt;
          s1_last <= beat_last;
`ifdef AES_FWD_SBOX_EN
          s1_fwd  <= mode_fwd;
`endif
        end
        if (s1_valid) begin
          out_data <= s2_nxt;
          out_last <= s1_last;
        end
      end
    end
  end

endmodule

// File: tb/tb_aes_inv_sbox_stream.sv
// Directed bench for aes_inv_sbox_stream, NUM_LANES=4.
// Covers reset, vectors, full sweep, backpressure, framing, err_frame.
module tb_aes_inv_sbox_stream;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        err_frame;
  logic        clr_err;
`ifdef AES_FWD_SBOX_EN
  logic        mode_fwd;
`endif

  int checks = 0;
  int errors = 0;

  localparam logic [7:0] INV [256] = '{
    8'h52,8'h09,8'h6a,8'hd5,8'h30,8'h36,8'ha5,8'h38,8'hbf,8'h40,8'ha3,8'h9e,8'h81,8'hf3,8'hd7,8'hfb,
    8'h7c,8'he3,8'h39,8'h82,8'h9b,8'h2f,8'hff,8'h87,8'h34,8'h8e,8'h43,8'h44,8'hc4,8'hde,8'he9,8'hcb,
    8'h54,8'h7b,8'h94,8'h32,8'ha6,8'hc2,8'h23,8'h3d,8'hee,8'h4c,8'h95,8'h0b,8'h42,8'hfa,8'hc3,8'h4e,
    8'h08,8'h2e,8'ha1,8'h66,8'h28,8'hd9,8'h24,8'hb2,8'h76,8'h5b,8'ha2,8'h49,8'h6d,8'h8b,8'hd1,8'h25,
    8'h72,8'hf8,8'hf6,8'h64,8'h86,8'h68,8'h98,8'h16,8'hd4,8'ha4,8'h5c,8'hcc,8'h5d,8'h65,8'hb6,8'h92,
    8'h6c,8'h70,8'h48,8'h50,8'hfd,8'hed,8'hb9,8'hda,8'h5e,8'h15,8'h46,8'h57,8'ha7,8'h8d,8'h9d,8'h84,
    8'h90,8'hd8,8'hab,8'h00,8'h8c,8'hbc,8'hd3,8'h0a,8'hf7,8'he4,8'h58,8'h05,8'hb8,8'hb3,8'h45,8'h06,
    8'hd0,8'h2c,8'h1e,8'h8f,8'hca,8'h3f,8'h0f,8'h02,8'hc1,8'haf,8'hbd,8'h03,8'h01,8'h13,8'h8a,8'h6b,
    8'h3a,8'h91,8'h11,8'h41,8'h4f,8'h67,8'hdc,8'hea,8'h97,8'hf2,8'hcf,8'hce,8'hf0,8'hb4,8'he6,8'h73,
    8'h96,8'hac,8'h74,8'h22,8'he7,8'had,8'h35,8'h85,8'he2,8'hf9,8'h37,8'he8,8'h1c,8'h75,8'hdf,8'h6e,
    8'h47,8'hf1,8'h1a,8'h71,8'h1d,8'h29,8'hc5,8'h89,8'h6f,8'hb7,8'h62,8'h0e,8'haa,8'h18,8'hbe,8'h1b,
    8'hfc,8'h56,8'h3e,8'h4b,8'hc6,8'hd2,8'h79,8'h20,8'h9a,8'hdb,8'hc0,8'hfe,8'h78,8'hcd,8'h5a,8'hf4,
    8'h1f,8'hdd,8'ha8,8'h33,8'h88,8'h07,8'hc7,8'h31,8'hb1,8'h12,8'h10,8'h59,8'h27,8'h80,8'hec,8'h5f,
    8'h60,8'h51,8'h7f,8'ha9,8'h19,8'hb5,8'h4a,8'h0d,8'h2d,8'he5,8'h7a,8'h9f,8'h93,8'hc9,8'h9c,8'hef,
    8'ha0,8'he0,8'h3b,8'h4d,8'hae,8'h2a,8'hf5,8'hb0,8'hc8,8'heb,8'hbb,8'h3c,8'h83,8'h53,8'h99,8'h61,
    8'h17,8'h2b,8'h04,8'h7e,8'hba,8'h77,8'hd6,8'h26,8'he1,8'h69,8'h14,8'h63,8'h55,8'h21,8'h0c,8'h7d
  };

  aes_inv_sbox_stream #(.NUM_LANES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .err_frame (err_frame),
    .clr_err   (clr_err)
`ifdef AES_FWD_SBOX_EN
    ,
    .mode_fwd  (mode_fwd)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] d, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
  endtask

  task automatic idle;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send1(input string tag, input logic [31:0] d,
                       input logic l, input logic [31:0] ed,
                       input logic el);
    drive(d, l);
    step;
    idle;
    chk({tag, "_lat"}, 32'(out_valid), 32'd0);
    step;
    chk({tag, "_v"}, 32'(out_valid), 32'd1);
    chk({tag, "_d"}, out_data, ed);
    chk({tag, "_l"}, 32'(out_last), 32'(el));
  endtask

  initial begin
    logic [31:0] exp;
    int b;
    rst_n     = 1'b0;
    out_ready = 1'b1;
    clr_err   = 1'b0;
`ifdef AES_FWD_SBOX_EN
    mode_fwd  = 1'b0;
`endif
    drive(32'h537C6300, 1'b0);
    step;
    step;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_err", 32'(err_frame), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);

    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", 32'(in_ready), 32'd1);
    step;
    idle;
    chk("a_lat", 32'(out_valid), 32'd0);
    step;
    chk("a_v", 32'(out_valid), 32'd1);
    chk("a_d", out_data, 32'h50010052);
    chk("a_l", 32'(out_last), 32'd0);
    send1("b", 32'h000000ED, 1'b0, 32'h52525253, 1'b0);
    send1("c", 32'h00000000, 1'b0, 32'h52525252, 1'b0);
    send1("d", 32'h63636363, 1'b1, 32'h00000000, 1'b1);
    chk("d_err", 32'(err_frame), 32'd0);

    // sweep: lane k carries (j + 64k) so every lane sees all 256 values
    for (int j = 0; j < 257; j++) begin
      if (j < 256) begin
        drive({8'(j + 192), 8'(j + 128), 8'(j + 64), 8'(j)},
              (j % 4) == 3);
      end else begin
        idle;
      end
      step;
      if (j >= 1) begin
        b   = j - 1;
        exp = {INV[8'(b + 192)], INV[8'(b + 128)],
               INV[8'(b + 64)], INV[8'(b)]};
        chk("sw_v", 32'(out_valid), 32'd1);
        chk("sw_d", out_data, exp);
        chk("sw_l", 32'(out_last), 32'((b % 4) == 3));
      end
    end
    step;
    chk("sw_drain", 32'(out_valid), 32'd0);
    chk("sw_err", 32'(err_frame), 32'd0);

    out_ready = 1'b0;
    drive(32'h01020304, 1'b0);
    step;
    drive(32'h10203040, 1'b0);
    step;
    chk("bp_v0", 32'(out_valid), 32'd1);
    chk("bp_d0", out_data, 32'h096ad530);
    drive(32'hFFFEFDFC, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step;
      chk("bp_hold_v", 32'(out_valid), 32'd1);
      chk("bp_hold_d", out_data, 32'h096ad530);
      chk("bp_hold_rdy", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    step;
    idle;
    chk("bp_v1", 32'(out_valid), 32'd1);
    chk("bp_d1", out_data, 32'h7c540872);
    step;
    chk("bp_v2", 32'(out_valid), 32'd1);
    chk("bp_d2", out_data, 32'h7d0c2155);
    chk("bp_l2", 32'(out_last), 32'd0);
    step;
    chk("bp_drain", 32'(out_valid), 32'd0);
    send1("bp3", 32'h80A0C0E0, 1'b1, 32'h3a471fa0, 1'b1);
    chk("bp_err", 32'(err_frame), 32'd0);

    drive(32'h00000000, 1'b0);
    step;
    idle;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_v", 32'(out_valid), 32'd0);
    chk("mid_rst_rdy", 32'(in_ready), 32'd0);
    step;
    rst_n = 1'b1;
    step;
    step;
    chk("mid_rst_noreplay", 32'(out_valid), 32'd0);

    send1("f0", 32'h00000000, 1'b0, 32'h52525252, 1'b0);
    send1("f1", 32'h52525252, 1'b1, 32'h48484848, 1'b1);
    chk("f1_err", 32'(err_frame), 32'd1);
    send1("g0", 32'h00000000, 1'b0, 32'h52525252, 1'b0);
    send1("g1", 32'h00000000, 1'b0, 32'h52525252, 1'b0);
    send1("g2", 32'h00000000, 1'b0, 32'h52525252, 1'b0);
    send1("g3", 32'h00000000, 1'b1, 32'h52525252, 1'b1);
    chk("g_sticky", 32'(err_frame), 32'd1);
    clr_err = 1'b1;
    step;
    clr_err = 1'b0;
    chk("clr", 32'(err_frame), 32'd0);

    drive(32'h00000000, 1'b1);
    clr_err = 1'b1;
    step;
    clr_err = 1'b0;
    idle;
    chk("clr_vs_err", 32'(err_frame), 32'd1);
    step;
    chk("clr_vs_err_l", 32'(out_last), 32'd1);
    clr_err = 1'b1;
    step;
    clr_err = 1'b0;
    chk("clr2", 32'(err_frame), 32'd0);

    send1("m0", 32'h00000000, 1'b0, 32'h52525252, 1'b0);
    send1("m1", 32'h00000000, 1'b0, 32'h52525252, 1'b0);
    send1("m2", 32'h00000000, 1'b0, 32'h52525252, 1'b0);
    chk("m2_err", 32'(err_frame), 32'd0);
    send1("m3", 32'h00000000, 1'b0, 32'h52525252, 1'b1);
    chk("m3_err", 32'(err_frame), 32'd1);

`ifdef AES_FWD_SBOX_EN
    mode_fwd = 1'b1;
    drive(32'h00530000, 1'b0);
    step;
    mode_fwd = 1'b0;
    drive(32'h000000ED, 1'b0);
    step;
    idle;
    chk("fwd_d", out_data, 32'h63ED6363);
    step;
    chk("fwd_inv_d", out_data, 32'h52525253);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
